// File: rtl/mvu_weight_streamer.sv
// Weight-side transmitter: holds one MH x MW weight matrix in on-chip memory and
// replays it as an AXI-Stream of PE x SIMD tiles for a programmable number of passes.
module mvu_weight_streamer #(
    parameter int MH           = 68,
    parameter int MW           = 48,
    parameter int PE           = 4,
    parameter int SIMD         = 3,
    parameter int WEIGHT_WIDTH = 4,
    parameter int PASS_WIDTH   = 16,
    localparam int NF          = MH / PE,
    localparam int SF          = MW / SIMD,
    localparam int DEPTH       = NF * SF,
    localparam int TILE_W      = PE * SIMD * WEIGHT_WIDTH,
    localparam int TILE_W_BA   = ((TILE_W + 7) / 8) * 8,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [TILE_W-1:0]     cfg_wdata,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] passes,
    output logic                  busy,
    output logic                  done,
    output logic [TILE_W_BA-1:0]  m_axis_weights_tdata,
    output logic                  m_axis_weights_tvalid,
    input  logic                  m_axis_weights_tready
);

    localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SFW-1:0] SF_LAST = SFW'(SF - 1);
    localparam logic [NFW-1:0] NF_LAST = NFW'(NF - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [TILE_W-1:0]       mem [DEPTH];
    logic [TILE_W-1:0]       rd_data;
    logic                    rd_valid;
    logic                    rd_en;
    logic                    rd_last;
    logic [AW-1:0]           rd_addr;
    logic [SFW-1:0]          sf_cnt;
    logic [NFW-1:0]          nf_cnt;
    logic [PASS_WIDTH-1:0]   pass_cnt;
    logic [PASS_WIDTH-1:0]   passes_q;
    logic [PASS_WIDTH-1:0]   pass_limit;
    logic                    done_nxt;
    logic [TILE_W-1:0]       buf0, buf1;
    logic [1:0]              count;
    logic                    pop;
    logic [1:0]              occ_after;

    assign busy                  = (state != IDLE);
    assign m_axis_weights_tvalid = (count != 2'd0);
    assign m_axis_weights_tdata  = TILE_W_BA'(buf0);
    assign pop                   = m_axis_weights_tvalid & m_axis_weights_tready;

    // Occupancy at the end of this cycle; counting the pop keeps reads flowing back to back.
    assign occ_after  = count + {1'b0, rd_valid} - {1'b0, pop};
    assign pass_limit = (state == IDLE) ? passes : passes_q;
    assign rd_addr    = AW'(nf_cnt) * AW'(SF) + AW'(sf_cnt);
    assign rd_last    = (sf_cnt == SF_LAST) && (nf_cnt == NF_LAST) &&
                        (pass_cnt == pass_limit - PASS_WIDTH'(1));

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // The first read is issued on the accepting edge so tvalid appears two cycles after start.
                if (start) begin
                    if (passes == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        rd_en     = 1'b1;
                        state_nxt = rd_last ? DRAIN : FETCH;
                    end
                end
            end
            FETCH: begin
                if (!occ_after[1]) begin
                    rd_en = 1'b1;
                    if (rd_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_valid && (count == 2'd0 || (count == 2'd1 && pop))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            sf_cnt   <= '0;
            nf_cnt   <= '0;
            pass_cnt <= '0;
            passes_q <= '0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            rd_valid <= rd_en;
            if (state == IDLE && start) passes_q <= passes;
            if (rd_en) begin
                if (rd_last) begin
                    sf_cnt   <= '0;
                    nf_cnt   <= '0;
                    pass_cnt <= '0;
                end else if (sf_cnt == SF_LAST) begin
                    sf_cnt <= '0;
                    if (nf_cnt == NF_LAST) begin
                        nf_cnt   <= '0;
                        pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                    end else begin
                        nf_cnt <= nf_cnt + NFW'(1);
                    end
                end else begin
                    sf_cnt <= sf_cnt + SFW'(1);
                end
            end
        end
    end

    // Weight memory stays unreset so it maps onto BRAM/LUTRAM.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) mem[cfg_addr] <= cfg_wdata;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Two-entry skid FIFO; buf0 is always the head and only moves on a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            case ({rd_valid, pop})
                2'b10: begin
                    if (count == 2'd0) buf0 <= rd_data;
                    else               buf1 <= rd_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf0 <= rd_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mvu_weight_streamer.sv
// Scoreboard bench for mvu_weight_streamer: a small 4x6 matrix instance plus an
// 18-bit-tile instance for the padding check.
module tb_mvu_weight_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [23:0] cfg_wdata = '0;
    logic        start = 1'b0;
    logic [15:0] passes = '0;
    logic        busy, done, tvalid;
    logic        tready = 1'b0;
    logic [23:0] tdata;

    logic        p_cfg_we = 1'b0;
    logic [1:0]  p_cfg_addr = '0;
    logic [17:0] p_cfg_wdata = '0;
    logic        p_start = 1'b0;
    logic [15:0] p_passes = '0;
    logic        p_busy, p_done, p_tvalid;
    logic        p_tready = 1'b0;
    logic [23:0] p_tdata;

    int tests_run = 0;
    int tests_failed = 0;

    logic [23:0] exp_q [$];
    logic [23:0] tile_val [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    logic [17:0] pad_val  [4] = '{18'h3FFFF, 18'h12345, 18'h2AAAA, 18'h15555};

    always #5 clk = ~clk;

    mvu_weight_streamer #(
        .MH(4), .MW(6), .PE(2), .SIMD(3), .WEIGHT_WIDTH(4), .PASS_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .passes(passes), .busy(busy), .done(done),
        .m_axis_weights_tdata(tdata), .m_axis_weights_tvalid(tvalid),
        .m_axis_weights_tready(tready)
    );

    mvu_weight_streamer #(
        .MH(4), .MW(6), .PE(2), .SIMD(3), .WEIGHT_WIDTH(3), .PASS_WIDTH(16)
    ) dut_pad (
        .clk(clk), .rst(rst), .cfg_we(p_cfg_we), .cfg_addr(p_cfg_addr), .cfg_wdata(p_cfg_wdata),
        .start(p_start), .passes(p_passes), .busy(p_busy), .done(p_done),
        .m_axis_weights_tdata(p_tdata), .m_axis_weights_tvalid(p_tvalid),
        .m_axis_weights_tready(p_tready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_matrix();
        for (int i = 0; i < 4; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 2'(i);
            cfg_wdata = tile_val[i];
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        tests_run++;
        if (tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tvalid: got %b expected 0", tvalid); end
        tests_run++;
        if (tdata !== 24'h0) begin tests_failed++; $display("[TB] FAIL reset_tdata: got %h expected 000000", tdata); end
        tests_run++;
        if (p_tdata !== 24'h0) begin tests_failed++; $display("[TB] FAIL reset_pad_tdata: got %h expected 000000", p_tdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        int hs = 0, first_v = -1, done_c = -1, done_n = 0;
        logic prev_busy = 1'b0, busy_before = 1'b0, busy_at = 1'b1;
        logic [23:0] exp;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(tile_val[i]);
        tready = 1'b1; passes = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                done_n++;
                if (done_c < 0) begin done_c = k; busy_at = busy; busy_before = prev_busy; end
            end
            if (tvalid && first_v < 0) first_v = k;
            if (tvalid && tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL single_extra_tile: got %h expected none", tdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (tdata !== exp) begin tests_failed++; $display("[TB] FAIL single_tdata: got %h expected %h", tdata, exp); end
                end
                hs++;
            end
            prev_busy = busy;
            tick();
        end
        tests_run++;
        if (first_v != 2) begin tests_failed++; $display("[TB] FAIL single_latency: got %0d expected 2", first_v); end
        tests_run++;
        if (hs != 4) begin tests_failed++; $display("[TB] FAIL single_count: got %0d expected 4", hs); end
        tests_run++;
        if (done_c != 6 || done_n != 1) begin
            tests_failed++; $display("[TB] FAIL single_done: got cycle %0d count %0d expected cycle 6 count 1", done_c, done_n);
        end
        tests_run++;
        if (busy_at !== 1'b0 || busy_before !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL single_busy_fall: got %b->%b expected 1->0", busy_before, busy_at);
        end
    endtask

    task automatic test_multi_pass();
        int hs = 0, gaps = 0, done_c = -1, done_n = 0;
        logic [23:0] exp;
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(tile_val[i % 4]);
        tready = 1'b1; passes = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (done) begin done_n++; if (done_c < 0) done_c = k; end
            if (k >= 2 && k <= 13 && !tvalid) gaps++;
            if (tvalid && tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL multi_extra_tile: got %h expected none", tdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (tdata !== exp) begin tests_failed++; $display("[TB] FAIL multi_tdata: got %h expected %h", tdata, exp); end
                end
                hs++;
            end
            tick();
        end
        tests_run++;
        if (gaps != 0) begin tests_failed++; $display("[TB] FAIL multi_bubbles: got %0d expected 0", gaps); end
        tests_run++;
        if (hs != 12) begin tests_failed++; $display("[TB] FAIL multi_count: got %0d expected 12", hs); end
        tests_run++;
        if (done_c != 14 || done_n != 1) begin
            tests_failed++; $display("[TB] FAIL multi_done: got cycle %0d count %0d expected cycle 14 count 1", done_c, done_n);
        end
    endtask

    task automatic test_backpressure();
        int hs = 0, done_n = 0, stall_left = 5;
        logic offered = 1'b0, prev_stall = 1'b0;
        logic [23:0] held = '0, exp;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(tile_val[i]);
        tready = 1'b0; passes = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            if (tvalid) offered = 1'b1;
            if (!offered) tready = 1'b0;
            else if (stall_left > 0) begin tready = 1'b0; stall_left--; end
            else tready = 1'($urandom_range(0, 1));
            if (done) done_n++;
            if (prev_stall) begin
                tests_run++;
                if (tvalid !== 1'b1 || tdata !== held) begin
                    tests_failed++; $display("[TB] FAIL stall_hold: got v=%b %h expected v=1 %h", tvalid, tdata, held);
                end
            end
            if (tvalid && tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL bp_extra_tile: got %h expected none", tdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (tdata !== exp) begin tests_failed++; $display("[TB] FAIL bp_tdata: got %h expected %h", tdata, exp); end
                end
                hs++;
            end
            prev_stall = tvalid && !tready;
            held = tdata;
            tick();
        end
        tready = 1'b1;
        tick();
        if (done) done_n++;
        tests_run++;
        if (hs != 4) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d expected 4", hs); end
        tests_run++;
        if (done_n != 1 || busy !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL bp_done: got count %0d busy %b expected count 1 busy 0", done_n, busy);
        end
    endtask

    task automatic test_zero_passes();
        int done_c = -1, done_n = 0, seen_v = 0, seen_b = 0;
        tready = 1'b1; passes = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (done) begin done_n++; if (done_c < 0) done_c = k; end
            if (tvalid) seen_v++;
            if (busy) seen_b++;
            tick();
        end
        tests_run++;
        if (done_c != 1 || done_n != 1) begin
            tests_failed++; $display("[TB] FAIL zero_done: got cycle %0d count %0d expected cycle 1 count 1", done_c, done_n);
        end
        tests_run++;
        if (seen_v != 0) begin tests_failed++; $display("[TB] FAIL zero_tvalid: got %0d cycles expected 0", seen_v); end
        tests_run++;
        if (seen_b != 0) begin tests_failed++; $display("[TB] FAIL zero_busy: got %0d cycles expected 0", seen_b); end
    endtask

    task automatic test_padding();
        int hs = 0, done_n = 0;
        logic [23:0] exp;
        for (int i = 0; i < 4; i++) begin
            p_cfg_we = 1'b1; p_cfg_addr = 2'(i); p_cfg_wdata = pad_val[i];
            tick();
        end
        p_cfg_we = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({6'b0, pad_val[i]});
        p_tready = 1'b1; p_passes = 16'd1; p_start = 1'b1;
        tick();
        p_start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (p_done) done_n++;
            if (p_tvalid) begin
                tests_run++;
                if (p_tdata[23:18] !== 6'b0) begin
                    tests_failed++; $display("[TB] FAIL pad_bits: got %h expected 00", p_tdata[23:18]);
                end
            end
            if (p_tvalid && p_tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL pad_extra_tile: got %h expected none", p_tdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (p_tdata !== exp) begin tests_failed++; $display("[TB] FAIL pad_tdata: got %h expected %h", p_tdata, exp); end
                end
                hs++;
            end
            tick();
        end
        tests_run++;
        if (hs != 4 || done_n != 1) begin
            tests_failed++; $display("[TB] FAIL pad_count: got %0d tiles %0d done expected 4 tiles 1 done", hs, done_n);
        end
    endtask

    task automatic test_reset_mid_run();
        int hs = 0, done_n = 0;
        logic [23:0] exp;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(tile_val[i % 4]);
        tready = 1'b1; passes = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (tvalid && tready) begin
                tests_run++;
                exp = exp_q.pop_front();
                if (tdata !== exp) begin tests_failed++; $display("[TB] FAIL midrst_tdata: got %h expected %h", tdata, exp); end
                hs++;
            end
            tick();
            if (hs == 3) break;
        end
        tests_run++;
        if (hs != 3) begin tests_failed++; $display("[TB] FAIL midrst_reach: got %0d handshakes expected 3", hs); end
        rst = 1'b1; tready = 1'b0;
        tick();
        tests_run++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL midrst_state: got v=%b b=%b d=%b expected 0 0 0", tvalid, busy, done);
        end
        rst = 1'b0;
        tick();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(tile_val[i]);
        hs = 0;
        tready = 1'b1; passes = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (done) done_n++;
            if (tvalid && tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL restart_extra_tile: got %h expected none", tdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (tdata !== exp) begin tests_failed++; $display("[TB] FAIL restart_tdata: got %h expected %h", tdata, exp); end
                end
                hs++;
            end
            tick();
        end
        tests_run++;
        if (hs != 4 || done_n != 1) begin
            tests_failed++; $display("[TB] FAIL restart_count: got %0d tiles %0d done expected 4 tiles 1 done", hs, done_n);
        end
    endtask

    task automatic test_ignored_during_busy();
        int hs = 0, done_n = 0, late_busy = 0;
        logic [23:0] exp;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(tile_val[i % 4]);
        tready = 1'b1; passes = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (done) done_n++;
            if (k > 12 && busy) late_busy++;
            if (tvalid && tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL busy_extra_tile: got %h expected none", tdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (tdata !== exp) begin tests_failed++; $display("[TB] FAIL busy_tdata: got %h expected %h", tdata, exp); end
                end
                hs++;
            end
            if (k == 3) begin
                cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 24'hABCDEF; start = 1'b1; passes = 16'd5;
            end else begin
                cfg_we = 1'b0; start = 1'b0; passes = 16'd2;
            end
            tick();
        end
        tests_run++;
        if (hs != 8 || done_n != 1) begin
            tests_failed++; $display("[TB] FAIL busy_count: got %0d tiles %0d done expected 8 tiles 1 done", hs, done_n);
        end
        tests_run++;
        if (late_busy != 0) begin tests_failed++; $display("[TB] FAIL busy_restart: got %0d busy cycles expected 0", late_busy); end
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(tile_val[i]);
        hs = 0;
        passes = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (tvalid && tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL readback_extra_tile: got %h expected none", tdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (tdata !== exp) begin tests_failed++; $display("[TB] FAIL readback_tdata: got %h expected %h", tdata, exp); end
                end
                hs++;
            end
            tick();
        end
        tests_run++;
        if (hs != 4) begin tests_failed++; $display("[TB] FAIL readback_count: got %0d expected 4", hs); end
    endtask

    initial begin
        test_reset();
        load_matrix();
        test_single_pass();
        test_multi_pass();
        test_backpressure();
        test_zero_passes();
        test_padding();
        test_reset_mid_run();
        test_ignored_during_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
